// File: rtl/fetch_queue.sv
// Instruction-fetch front end with a decoupled prefetch queue.
// Sequential PCs are issued to instruction memory and responses are buffered
// in a circular queue until decode consumes them. A redirect flushes the queue.
// Responses still owed to the old stream are discarded using a drop counter.
module fetch_queue #(
   parameter int unsigned     XLEN         = 32,
   parameter int unsigned     DEPTH        = 4,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_pc,
   output logic [31:0]     inst_data
);

   localparam int unsigned AW = $clog2(DEPTH);
   // Counters must be able to hold DEPTH itself.
   localparam int unsigned CW = AW + 1;

   logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0]  pc_q   [DEPTH];
   logic [31:0]      data_q [DEPTH];
   logic [DEPTH-1:0] filled_q, filled_d;
   logic [AW-1:0]    alloc_q, alloc_d;
   logic [AW-1:0]    fill_q, fill_d;
   logic [AW-1:0]    head_q, head_d;
   logic [CW-1:0]    count_q, count_d;
   // Responses still owed to flushed streams.
   logic [CW-1:0]    drop_q, drop_d;
   // Allocated entries of the current stream that still await their response.
   logic [CW-1:0]    pend_q, pend_d;

   logic [CW:0] credit_used;
   logic        req_fire;
   logic        deq;
   logic        resp_drop;
   logic        resp_fill;

   // Handshake decode and credit check.
   always_comb begin
      credit_used    = {1'b0, count_q} + {1'b0, drop_q};
      imem_req_valid = ~rst & ~redirect_valid & (credit_used < (CW+1)'(DEPTH));
      imem_req_addr  = fetch_pc_q;
      req_fire       = imem_req_valid & imem_req_ready;
      inst_valid     = ~rst & ~redirect_valid & filled_q[head_q];
      inst_pc        = pc_q[head_q];
      inst_data      = data_q[head_q];
      deq            = inst_valid & inst_ready;
      resp_drop      = imem_resp_valid & (drop_q != '0);
      // A response with nothing owed and nothing pending is ignored.
      resp_fill      = imem_resp_valid & (drop_q == '0) & (pend_q != '0);
   end

   // Next-state for pointers, counters and fetch PC.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      filled_d   = filled_q;
      alloc_d    = alloc_q;
      fill_d     = fill_q;
      head_d     = head_q;
      count_d    = count_q;
      drop_d     = drop_q;
      pend_d     = pend_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
         filled_d   = '0;
         alloc_d    = '0;
         fill_d     = '0;
         head_d     = '0;
         count_d    = '0;
         pend_d     = '0;
         // Every unfilled entry becomes a response to drop; one arriving now
         // is consumed immediately.
         drop_d     = drop_q + pend_q - CW'(resp_drop | resp_fill);
      end else begin
         if (req_fire) begin
            alloc_d    = alloc_q + 1'b1;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         if (resp_drop) begin
            drop_d = drop_q - 1'b1;
         end
         if (resp_fill) begin
            filled_d[fill_q] = 1'b1;
            fill_d           = fill_q + 1'b1;
         end
         if (deq) begin
            filled_d[head_q] = 1'b0;
            head_d           = head_q + 1'b1;
         end
         count_d = count_q + CW'(req_fire) - CW'(deq);
         pend_d  = pend_q + CW'(req_fire) - CW'(resp_fill);
      end
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q <= RESET_VECTOR;
         filled_q   <= '0;
         alloc_q    <= '0;
         fill_q     <= '0;
         head_q     <= '0;
         count_q    <= '0;
         drop_q     <= '0;
         pend_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         filled_q   <= filled_d;
         alloc_q    <= alloc_d;
         fill_q     <= fill_d;
         head_q     <= head_d;
         count_q    <= count_d;
         drop_q     <= drop_d;
         pend_q     <= pend_d;
      end
   end

   // Queue payload storage; validity lives in filled_q so no reset is needed.
   always_ff @(posedge clk) begin
      if (!rst && !redirect_valid) begin
         if (req_fire) begin
            pc_q[alloc_q] <= fetch_pc_q;
         end
         if (resp_fill) begin
            data_q[fill_q] <= imem_resp_data;
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: an in-order variable-latency memory
// model plus a stream-level reference (next PC to request, next PC to deliver).
module tb_fetch_queue;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned DEPTH = 4;
   localparam logic [31:0] RV    = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic [31:0] inst_pc;
   logic [31:0] inst_data;

   always #5 clk = ~clk;

   fetch_queue #(
      .XLEN        (XLEN),
      .DEPTH       (DEPTH),
      .RESET_VECTOR(RV)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_pc        (inst_pc),
      .inst_data      (inst_data)
   );

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } mreq_t;

   mreq_t mq[$];

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;
   int unsigned rdy_pct  = 100;
   int unsigned ird_pct  = 100;
   int unsigned lat_min  = 1;
   int unsigned lat_max  = 1;
   int unsigned n_req_fire  = 0;
   int unsigned n_inst_fire = 0;

   logic [31:0] exp_req  = RV;
   logic [31:0] exp_inst = RV;

   logic        s_req_valid, s_inst_valid, s_req_fire, s_inst_fire;
   logic [31:0] s_req_addr, s_inst_pc;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive inputs, check outputs at negedge, update model after posedge.
   task automatic cycle(input logic do_rst, input logic do_redir, input logic [31:0] rpc);
      rst            = do_rst;
      redirect_valid = do_redir;
      redirect_pc    = rpc;
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      inst_ready     = ($urandom_range(99) < ird_pct);
      if (!do_rst && mq.size() > 0 && mq[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = memfn(mq[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
      @(negedge clk);
      s_req_valid  = imem_req_valid;
      s_req_addr   = imem_req_addr;
      s_inst_valid = inst_valid;
      s_inst_pc    = inst_pc;
      s_req_fire   = imem_req_valid & imem_req_ready;
      s_inst_fire  = inst_valid & inst_ready;
      if (do_rst || do_redir) begin
         check("blocked_req_valid", 32'(imem_req_valid), 32'd0);
         check("blocked_inst_valid", 32'(inst_valid), 32'd0);
      end
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_req);
      if (inst_valid) begin
         check("inst_pc", inst_pc, exp_inst);
         check("inst_data", inst_data, memfn(exp_inst));
      end
      @(posedge clk);
      #1;
      if (do_rst) begin
         mq.delete();
         exp_req  = RV;
         exp_inst = RV;
      end else begin
         if (imem_resp_valid) void'(mq.pop_front());
         if (do_redir) begin
            exp_req  = rpc;
            exp_inst = rpc;
         end else begin
            if (s_req_fire) begin
               mq.push_back('{addr: s_req_addr, due: cyc + $urandom_range(lat_max, lat_min)});
               check("inflight_le_depth", 32'(mq.size() <= DEPTH), 32'd1);
               exp_req += 32'd4;
               n_req_fire++;
            end
            if (s_inst_fire) begin
               exp_inst += 32'd4;
               n_inst_fire++;
            end
         end
      end
      cyc++;
   endtask

   task automatic wait_first_inst(input string tag, input logic [31:0] pc, input int bound);
      bit found = 1'b0;
      for (int i = 0; i < bound && !found; i++) begin
         cycle(1'b0, 1'b0, 32'd0);
         if (s_inst_valid) begin
            found = 1'b1;
            check(tag, s_inst_pc, pc);
         end
      end
      check({tag, "_seen"}, 32'(found), 32'd1);
   endtask

   task automatic set_mode(input int unsigned rdy, input int unsigned ird,
                           input int unsigned lmin, input int unsigned lmax);
      rdy_pct = rdy;
      ird_pct = ird;
      lat_min = lmin;
      lat_max = lmax;
   endtask

   initial begin
      int unsigned n0;
      int unsigned r;

      // Straight-line fetch with 1-cycle memory: first delivery 2 cycles after release.
      set_mode(100, 100, 1, 1);
      repeat (3) cycle(1'b1, 1'b0, 32'd0);
      for (int i = 0; i < 12; i++) begin
         cycle(1'b0, 1'b0, 32'd0);
         check("t1_inst_valid", 32'(s_inst_valid), (i >= 2) ? 32'd1 : 32'd0);
         check("t1_req_valid", 32'(s_req_valid), 32'd1);
      end

      // Decode stalled: exactly DEPTH requests, then drain with no bubbles and wrap.
      set_mode(100, 0, 1, 1);
      repeat (2) cycle(1'b1, 1'b0, 32'd0);
      n0 = n_req_fire;
      repeat (10) cycle(1'b0, 1'b0, 32'd0);
      check("t2_req_count", n_req_fire - n0, DEPTH);
      check("t2_req_stalled", 32'(s_req_valid), 32'd0);
      ird_pct = 100;
      n0 = n_inst_fire;
      repeat (12) cycle(1'b0, 1'b0, 32'd0);
      check("t2_drain_count", n_inst_fire - n0, 32'd12);

      // Three requests in flight at latency 4, then redirect.
      set_mode(100, 100, 4, 4);
      repeat (2) cycle(1'b1, 1'b0, 32'd0);
      n0 = n_req_fire;
      repeat (3) cycle(1'b0, 1'b0, 32'd0);
      check("t3_inflight", n_req_fire - n0, 32'd3);
      cycle(1'b0, 1'b1, 32'h8000_0100);
      wait_first_inst("t3_first_pc", 32'h8000_0100, 30);
      repeat (6) cycle(1'b0, 1'b0, 32'd0);

      // Redirect coincident with a response while two entries are unfilled.
      set_mode(100, 100, 2, 2);
      repeat (2) cycle(1'b1, 1'b0, 32'd0);
      repeat (2) cycle(1'b0, 1'b0, 32'd0);
      cycle(1'b0, 1'b1, 32'h8000_0040);
      wait_first_inst("t4_first_pc", 32'h8000_0040, 30);
      repeat (6) cycle(1'b0, 1'b0, 32'd0);

      // Back-to-back redirects with two in flight; the last target wins.
      set_mode(100, 100, 3, 3);
      repeat (2) cycle(1'b1, 1'b0, 32'd0);
      repeat (2) cycle(1'b0, 1'b0, 32'd0);
      cycle(1'b0, 1'b1, 32'h8000_0100);
      cycle(1'b0, 1'b1, 32'h8000_0200);
      wait_first_inst("t5_first_pc", 32'h8000_0200, 30);
      repeat (6) cycle(1'b0, 1'b0, 32'd0);

      // Reset mid-stream with the queue full and requests outstanding.
      set_mode(80, 0, 1, 4);
      repeat (2) cycle(1'b1, 1'b0, 32'd0);
      repeat (6) cycle(1'b0, 1'b0, 32'd0);
      cycle(1'b1, 1'b0, 32'd0);
      rdy_pct = 100;
      cycle(1'b0, 1'b0, 32'd0);
      check("t6_req_valid", 32'(s_req_valid), 32'd1);
      check("t6_req_addr", s_req_addr, RV);
      check("t6_inst_valid", 32'(s_inst_valid), 32'd0);
      ird_pct = 100;
      wait_first_inst("t6_first_pc", RV, 20);

      // Randomised traffic with redirects and occasional resets.
      set_mode(70, 60, 1, 5);
      n0 = n_inst_fire;
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(999);
         cycle(r < 5, (r >= 5) && (r < 40), {RV[31:12], 10'($urandom), 2'b00});
      end
      check("rand_progress", 32'(n_inst_fire - n0 > 300), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Guard against a stuck simulation.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
